// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: loads/stores over a req/ack bus, writeback forwarding
module mem_stage #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] data,
   input  logic [XLEN-1:0] store_val,
   output logic            stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            out_valid,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_en,
   output logic            misalign,
   output logic            bus_err
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t          r_state;
   logic [7:0]      r_cnt;
   logic [2:0]      r_f3;
   logic [1:0]      r_off;
   logic            r_is_load;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic            r_dmem_req;
   logic            r_dmem_we;
   logic [XLEN-1:0] r_dmem_addr;
   logic [3:0]      r_dmem_be;
   logic [XLEN-1:0] r_dmem_wdata;
   logic            r_out_valid;
   logic [XLEN-1:0] r_pc_out;
   logic [XLEN-1:0] r_instr_out;
   logic [XLEN-1:0] r_wb_data;
   logic [4:0]      r_wb_rd;
   logic            r_wb_en;
   logic            r_misalign;
   logic            r_bus_err;

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [4:0]      w_rd;
   logic [1:0]      w_off;
   logic            w_is_load;
   logic            w_is_mem;
   logic            w_aligned;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_lane;
   logic [XLEN-1:0] w_load_val;
   logic [7:0]      w_cnt_next;

   assign w_opcode   = instr_in[6:0];
   assign w_f3       = instr_in[14:12];
   assign w_rd       = instr_in[11:7];
   assign w_off      = data[1:0];
   assign w_is_load  = (w_opcode == OP_LOAD);
   assign w_is_mem   = w_is_load || (w_opcode == OP_STORE);
   assign w_cnt_next = r_cnt + 8'd1;

   // Alignment check from access size and low address bits; reserved sizes count as faults
   always_comb begin
      w_aligned = 1'b0;
      case (w_f3[1:0])
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~w_off[0];
         2'b10:   w_aligned = (w_off == 2'b00) && (w_f3 != 3'b110);
         default: w_aligned = 1'b0;
      endcase
   end

   // Byte enables and lane-replicated store data for the incoming access
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = store_val;
      case (w_f3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{store_val[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{store_val[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = store_val;
         end
      endcase
   end

   // Shift the returned word down to the addressed lane and extend to XLEN
   always_comb begin
      w_lane     = dmem_rdata >> {r_off, 3'b000};
      w_load_val = w_lane;
      case (r_f3)
         3'b000:  w_load_val = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_load_val = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
         3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_lane[7:0]};
         3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_lane[15:0]};
         default: w_load_val = w_lane;
      endcase
   end

   // Stage FSM: accept in IDLE, hold the bus request in BUSY until ack or timeout, then retire
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         r_f3         <= 3'd0;
         r_off        <= 2'd0;
         r_is_load    <= 1'b0;
         r_rd         <= 5'd0;
         r_pc         <= '0;
         r_instr      <= '0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_be    <= 4'd0;
         r_dmem_wdata <= '0;
         r_out_valid  <= 1'b0;
         r_pc_out     <= '0;
         r_instr_out  <= '0;
         r_wb_data    <= '0;
         r_wb_rd      <= 5'd0;
         r_wb_en      <= 1'b0;
         r_misalign   <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_misalign  <= 1'b0;
         r_bus_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_f3      <= w_f3;
                  r_off     <= w_off;
                  r_is_load <= w_is_load;
                  r_rd      <= w_rd;
                  r_pc      <= pc_in;
                  r_instr   <= instr_in;
                  if (!w_is_mem || !w_aligned) begin
                     // Retire immediately: ALU result, or a faulting access with no bus cycle
                     r_out_valid <= 1'b1;
                     r_pc_out    <= pc_in;
                     r_instr_out <= instr_in;
                     r_wb_data   <= data;
                     r_wb_rd     <= w_rd;
                     r_wb_en     <= !w_is_mem && (w_opcode != OP_BRANCH) && (w_rd != 5'd0);
                     r_misalign  <= w_is_mem;
                  end else begin
                     r_state      <= S_BUSY;
                     r_cnt        <= 8'd0;
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= !w_is_load;
                     r_dmem_addr  <= {data[XLEN-1:2], 2'b00};
                     r_dmem_be    <= w_be;
                     r_dmem_wdata <= w_is_load ? '0 : w_wdata;
                  end
               end
            end
            S_BUSY: begin
               if (dmem_ack || (w_cnt_next == TMO_LIMIT)) begin
                  r_state     <= S_IDLE;
                  r_cnt       <= 8'd0;
                  r_dmem_req  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_pc_out    <= r_pc;
                  r_instr_out <= r_instr;
                  r_wb_rd     <= r_rd;
                  // Ack takes priority over a timeout landing in the same cycle
                  r_wb_data   <= (dmem_ack && r_is_load) ? w_load_val : '0;
                  r_wb_en     <= dmem_ack && r_is_load && (r_rd != 5'd0);
                  r_bus_err   <= !dmem_ack;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall      = (r_state == S_BUSY);
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_be    = r_dmem_be;
   assign dmem_wdata = r_dmem_wdata;
   assign out_valid  = r_out_valid;
   assign pc_out     = r_pc_out;
   assign instr_out  = r_instr_out;
   assign wb_data    = r_wb_data;
   assign wb_rd      = r_wb_rd;
   assign wb_en      = r_wb_en;
   assign misalign   = r_misalign;
   assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed vector bench for mem_stage
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] pc_in, instr_in, data, store_val;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic        out_valid;
   logic [31:0] pc_out, instr_out, wb_data;
   logic [4:0]  wb_rd;
   logic        wb_en, misalign, bus_err;

   int n_vec = 0;
   int n_err = 0;

   mem_stage #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instr_in(instr_in),
      .data(data), .store_val(store_val), .stall(stall), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid), .pc_out(pc_out),
      .instr_out(instr_out), .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
      .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic [31:0] sv;
      logic [31:0] rdata;
      int          delay;
      logic        is_store;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        chk_wb;
      logic [31:0] e_wb;
      logic [4:0]  e_rd;
      logic        e_en;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
      return {17'h0_1234 & 17'h1ffff, f3, rd, op};
   endfunction

   task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] addr, input logic [31:0] sv, input logic [31:0] rdata,
                      input int delay, input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wdata, input logic chk_wb, input logic [31:0] e_wb,
                      input logic e_en, input logic e_mis);
      vec_t v;
      v.instr = mk(op, f3, rd); v.addr = addr; v.sv = sv; v.rdata = rdata; v.delay = delay;
      v.is_store = (op == 7'b0100011); v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
      v.chk_wb = chk_wb; v.e_wb = e_wb; v.e_rd = rd; v.e_en = e_en; v.e_mis = e_mis;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int nst;
      string p;
      p = $sformatf("v%0d", i);
      in_valid = 1'b1; pc_in = 32'h100 + 32'(i * 4); instr_in = v.instr;
      data = v.addr; store_val = v.sv;
      tick();
      in_valid = 1'b0;
      if (v.delay == 0) begin
         chk({p, " req"}, {31'd0, dmem_req}, 32'd0);
         chk({p, " stall"}, {31'd0, stall}, 32'd0);
      end else begin
         chk({p, " req"}, {31'd0, dmem_req}, 32'd1);
         chk({p, " addr"}, dmem_addr, v.e_addr);
         chk({p, " we"}, {31'd0, dmem_we}, {31'd0, v.is_store});
         if (v.is_store) begin
            chk({p, " be"}, {28'd0, dmem_be}, {28'd0, v.e_be});
            chk({p, " wdata"}, dmem_wdata, v.e_wdata);
         end
         nst = 0;
         for (int k = 1; k <= v.delay; k++) begin
            if (k == v.delay) begin
               dmem_ack = 1'b1; dmem_rdata = v.rdata;
            end
            nst += int'(stall);
            tick();
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
         end
         chk({p, " stall cycles"}, 32'(nst), 32'(v.delay));
         chk({p, " req after ack"}, {31'd0, dmem_req}, 32'd0);
      end
      chk({p, " out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({p, " wb_rd"}, {27'd0, wb_rd}, {27'd0, v.e_rd});
      chk({p, " wb_en"}, {31'd0, wb_en}, {31'd0, v.e_en});
      chk({p, " misalign"}, {31'd0, misalign}, {31'd0, v.e_mis});
      chk({p, " bus_err"}, {31'd0, bus_err}, 32'd0);
      chk({p, " pc_out"}, pc_out, 32'h100 + 32'(i * 4));
      chk({p, " instr_out"}, instr_out, v.instr);
      if (v.chk_wb) chk({p, " wb_data"}, wb_data, v.e_wb);
      tick();
      chk({p, " pulse end"}, {30'd0, out_valid, misalign}, 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; pc_in = '0; instr_in = '0; data = '0; store_val = '0;
      dmem_rdata = '0; dmem_ack = 1'b0;

      //   op        f3      rd  addr          sv            rdata         dly addr          be       wdata        chk wb            en mis
      add(7'h33, 3'b000, 5'd5, 32'h0000_0042, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0000_0042, 1, 0);
      add(7'h63, 3'b000, 5'd5, 32'h0000_0010, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0000_0010, 0, 0);
      add(7'h13, 3'b000, 5'd0, 32'h0000_1234, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0000_1234, 0, 0);
      add(7'h03, 3'b000, 5'd7, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 32'h0000_1000, 4'h0, 32'h0,       1, 32'hFFFF_FF80, 1, 0);
      add(7'h03, 3'b100, 5'd7, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 32'h0000_1000, 4'h0, 32'h0,       1, 32'h0000_0080, 1, 0);
      add(7'h23, 3'b001, 5'd9, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,       3, 32'h0000_2000, 4'hC, 32'hBEEF_BEEF, 0, 32'h0,        0, 0);
      add(7'h03, 3'b010, 5'd4, 32'h0000_3001, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,         0, 1);
      add(7'h03, 3'b001, 5'd8, 32'h0000_1002, 32'h0,        32'h80FF_1234, 2, 32'h0000_1000, 4'h0, 32'h0,       1, 32'hFFFF_80FF, 1, 0);
      add(7'h03, 3'b101, 5'd8, 32'h0000_1002, 32'h0,        32'h80FF_1234, 2, 32'h0000_1000, 4'h0, 32'h0,       1, 32'h0000_80FF, 1, 0);
      add(7'h03, 3'b010, 5'd3, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 1, 32'h0000_4000, 4'h0, 32'h0,       1, 32'hCAFE_F00D, 1, 0);
      add(7'h23, 3'b000, 5'd1, 32'h0000_5001, 32'h0000_00A5, 32'h0,       1, 32'h0000_5000, 4'h2, 32'hA5A5_A5A5, 0, 32'h0,        0, 0);
      add(7'h23, 3'b010, 5'd1, 32'h0000_6000, 32'h1234_5678, 32'h0,       2, 32'h0000_6000, 4'hF, 32'h1234_5678, 0, 32'h0,        0, 0);
      add(7'h03, 3'b001, 5'd2, 32'h0000_1001, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,         0, 1);
      add(7'h03, 3'b011, 5'd2, 32'h0000_0000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,         0, 1);
      add(7'h23, 3'b110, 5'd2, 32'h0000_0000, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0, 32'h0,         0, 1);
      add(7'h03, 3'b010, 5'd0, 32'h0000_7000, 32'h0,        32'h0000_0001, 1, 32'h0000_7000, 4'h0, 32'h0,       1, 32'h0000_0001, 0, 0);
      add(7'h03, 3'b000, 5'd6, 32'h0000_1000, 32'h0,        32'h80FF_1234, 1, 32'h0000_1000, 4'h0, 32'h0,       1, 32'h0000_0034, 1, 0);
      add(7'h03, 3'b010, 5'd6, 32'h0000_8000, 32'h0,        32'h1122_3344, 4, 32'h0000_8000, 4'h0, 32'h0,       1, 32'h1122_3344, 1, 0);

      tick(); tick();
      rst = 1'b0;
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset req", {31'd0, dmem_req}, 32'd0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset wb", wb_data | pc_out | instr_out | dmem_addr | dmem_wdata, 32'd0);
      chk("reset flags", {26'd0, wb_rd, wb_en} | {28'd0, dmem_be} | {29'd0, dmem_we, misalign, bus_err}, 32'd0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Back-to-back ALU ops retire one per cycle
      in_valid = 1'b1; pc_in = 32'h200; instr_in = mk(7'h33, 3'b000, 5'd10); data = 32'hAAAA_0001;
      tick();
      chk("b2b first valid", {31'd0, out_valid}, 32'd1);
      chk("b2b first data", wb_data, 32'hAAAA_0001);
      pc_in = 32'h204; instr_in = mk(7'h33, 3'b000, 5'd11); data = 32'hBBBB_0002;
      tick();
      in_valid = 1'b0;
      chk("b2b second valid", {31'd0, out_valid}, 32'd1);
      chk("b2b second data", wb_data, 32'hBBBB_0002);
      chk("b2b second rd", {27'd0, wb_rd}, 32'd11);
      chk("b2b second pc", pc_out, 32'h204);
      tick();
      chk("b2b idle", {31'd0, out_valid}, 32'd0);
      chk("b2b hold data", wb_data, 32'hBBBB_0002);

      // Timeout: no ack, request held for TIMEOUT cycles then bus_err
      in_valid = 1'b1; pc_in = 32'h300; instr_in = mk(7'h03, 3'b010, 5'd12); data = 32'h0000_9000;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (dmem_req && n < 20) begin
         n++;
         tick();
      end
      chk("tmo req cycles", 32'(n), 32'd4);
      chk("tmo out_valid", {31'd0, out_valid}, 32'd1);
      chk("tmo bus_err", {31'd0, bus_err}, 32'd1);
      chk("tmo wb_en", {31'd0, wb_en}, 32'd0);
      chk("tmo stall", {31'd0, stall}, 32'd0);
      tick();
      chk("tmo pulse end", {30'd0, out_valid, bus_err}, 32'd0);

      // Reset in the 2nd BUSY cycle, late ack must be ignored
      in_valid = 1'b1; pc_in = 32'h400; instr_in = mk(7'h03, 3'b010, 5'd13); data = 32'h0000_A000;
      tick();
      in_valid = 1'b0;
      tick();
      chk("rst busy req", {31'd0, dmem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
      chk("rst req dropped", {31'd0, dmem_req}, 32'd0);
      chk("rst stall low", {31'd0, stall}, 32'd0);
      tick();
      dmem_ack = 1'b0;
      chk("rst no retire", {31'd0, out_valid}, 32'd0);
      chk("rst outputs zero", wb_data | pc_out | instr_out | dmem_addr, 32'd0);
      chk("rst still idle", {30'd0, stall, dmem_req}, 32'd0);
      tick();
      chk("rst ack ignored", {31'd0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage after Execute; consumes Execute's pc_out, instr_out, data (ALU result / effective address) and store_val.
- Performs RV32I loads and stores on a req/ack data-memory bus, then forwards the writeback value, destination register and write enable to the register file.
- Drives stall back to Execute's stall_e while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath and address width (word_t width)
TIMEOUT, 255, BUSY cycles without dmem_ack before bus_err is raised (8-bit counter; valid range 1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  Execute outputs hold a valid instruction
pc_in  in  XLEN  pc from Execute
instr_in  in  XLEN  instruction from Execute
data  in  XLEN  ALU result; effective address for LOAD/STORE
store_val  in  XLEN  rs2 value for stores
stall  out  1  hold Execute; input not accepted while high
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  word-aligned address (data with bits [1:0] = 0)
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-aligned store data
dmem_rdata  in  XLEN  load data, valid with dmem_ack
dmem_ack  in  1  transaction complete
out_valid  out  1  one-cycle pulse per retired instruction
pc_out  out  XLEN  pc of retired instruction
instr_out  out  XLEN  instruction of retired instruction
wb_data  out  XLEN  writeback value
wb_rd  out  5  instr[11:7]
wb_en  out  1  register write enable
misalign  out  1  alignment fault, valid with out_valid
bus_err  out  1  ack timeout, valid with out_valid

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset during BUSY drops dmem_req in the next cycle; an ack arriving after reset is ignored.
- FSM states:
  - IDLE; stall = 0.
  - BUSY; stall = 1. dmem_req/we/addr/be/wdata are registered and held stable for the whole of BUSY.
- Input accepted when in_valid and state = IDLE. For an accepted instruction, pc/instr are registered to pc_out/instr_out.
- Non-memory op (opcode is not LOAD or STORE):
  - Retires the next cycle: out_valid = 1, wb_data = data.
  - wb_en = 1 except for BRANCH, or when rd = 0.
- Alignment rule, using funct3[1:0] and addr[1:0]:
  - byte: always aligned.
  - half: addr[0] = 0.
  - word: addr[1:0] = 0.
  - funct3 = 011, 110 or 111 is treated as misaligned.
- Misaligned LOAD/STORE: no bus request. Retires the next cycle with misalign = 1, wb_en = 0.
- Aligned LOAD/STORE: IDLE -> BUSY with dmem_req = 1. dmem_ack is sampled only in BUSY.
  - On ack: BUSY -> IDLE, dmem_req = 0 in the same registered update, and out_valid in the next cycle.
  - Minimum latency is 2 cycles from accept to out_valid.
- Store lanes, with off = addr[1:0]:
  - SB: be = 4'b0001 << off; wdata = byte replicated x4.
  - SH: be = 4'b0011 << off; wdata = half replicated x2.
  - SW: be = 4'b1111; wdata = store_val.
  - Stores: wb_en = 0.
- Load extract, with lane shift = rdata >> (8*off):
  - LB / LH: sign-extended.
  - LBU / LHU: zero-extended.
  - LW: full word.
  - wb_en = (rd != 0).
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT: exit to IDLE, drop req, retire with bus_err = 1, wb_en = 0.
  - Ack and timeout in the same cycle: ack wins.
- out_valid, misalign and bus_err are single-cycle pulses. wb_data/wb_rd/pc_out/instr_out hold their value until the next retirement.
- in_valid while BUSY is ignored; Execute holds its outputs because stall = 1.
- Back-to-back non-memory ops retire one per cycle.

Test Plan:
- ADD retires: data = 0x0000_0042, rd = 5, accepted at t0 -> out_valid at t1, wb_data = 0x42, wb_rd = 5, wb_en = 1, no dmem_req.
- LB with sign extension: addr 0x1003, rdata = 0x80FF_1234, ack on 1st BUSY cycle -> dmem_addr = 0x1000, stall high 1 cycle, wb_data = 0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
- SH to addr 0x2002, store_val = 0xDEAD_BEEF, ack after 3 cycles -> dmem_be = 4'b1100, wdata = 0xBEEF_BEEF, dmem_we = 1, stall high 3 cycles, wb_en = 0.
- LW at 0x3001 -> no dmem_req, out_valid next cycle with misalign = 1, wb_en = 0.
- Aligned LW with TIMEOUT = 4 and no ack -> dmem_req high 4 cycles then low, bus_err = 1 pulse; an ack in cycle 4 instead gives a normal load.
- rst asserted in the 2nd BUSY cycle, ack the cycle after -> dmem_req = 0, stall = 0, out_valid stays 0, outputs all 0.
